// File: rtl/spi_cmd_slave.sv
// SPI command slave in the system clock domain: oversamples sck/sel/sdi,
// decodes {nrep, adr, data} frames, shifts out status and an optional reply.
module spi_cmd_slave #(
   parameter int unsigned REPLY_WIDTH = 8,
   parameter int unsigned COMM_WIDTH  = 8,
   parameter int unsigned ADR_WIDTH   = 3,
   parameter int unsigned STAT_WIDTH  = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sck,
   input  logic                   sel,
   input  logic                   sdi,
   output logic                   sdo,
   input  logic [STAT_WIDTH-1:0]  status,
   input  logic [REPLY_WIDTH-1:0] reply_data,
   output logic                   reply_req,
   output logic                   cmd_valid,
   output logic [ADR_WIDTH-1:0]   cmd_adr,
   output logic [COMM_WIDTH-1:0]  cmd_data,
   output logic                   cmd_reply,
   output logic                   frame_err,
   output logic                   busy
);

   localparam int unsigned FRAME = 1 + ADR_WIDTH + COMM_WIDTH;
   localparam int unsigned NW    = $clog2(FRAME + 2);
   localparam int unsigned SW    = ADR_WIDTH + COMM_WIDTH;

   typedef enum logic [2:0] {IDLE, FLAG, ADDR, DATA, DONE} state_t;

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
   logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
   logic                   sck_prev_q, sck_prev_d;
   logic                   sck_s, sel_s, sdi_s, sck_fall;

   state_t                 state_q, state_d;
   logic [NW-1:0]          n_q, n_d, n_inc;
   logic                   armed_q, armed_d;
   logic                   nrep_q, nrep_d;
   logic [SW-1:0]          shift_q, shift_d;
   logic [REPLY_WIDTH-1:0] reply_sh_q, reply_sh_d;
   logic                   sdo_q, sdo_d;
   logic                   reply_req_q, reply_req_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   busy_q, busy_d;
   logic                   cmd_reply_q, cmd_reply_d;
   logic [ADR_WIDTH-1:0]   cmd_adr_q, cmd_adr_d;
   logic [COMM_WIDTH-1:0]  cmd_data_q, cmd_data_d;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign sel_s    = sel_sync_q[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
   assign sck_fall = sck_prev_q & ~sck_s;

   // Synchronizer shift chains and previous-sck tap for edge detection
   always_comb begin
      sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
      sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], sel};
      sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      sck_prev_d = sck_s;
   end

   // Synchronizer registers; sel resets low so a held-low sel cannot arm the FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync_q <= '0;
         sel_sync_q <= '0;
         sdi_sync_q <= '0;
         sck_prev_q <= 1'b0;
      end else begin
         sck_sync_q <= sck_sync_d;
         sel_sync_q <= sel_sync_d;
         sdi_sync_q <= sdi_sync_d;
         sck_prev_q <= sck_prev_d;
      end
   end

   // Frame FSM: next state, bit counting, sdo shifting and end-of-frame decode
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      armed_d     = armed_q | sel_s;
      nrep_d      = nrep_q;
      shift_d     = shift_q;
      reply_sh_d  = reply_sh_q;
      sdo_d       = sdo_q;
      reply_req_d = 1'b0;
      cmd_valid_d = 1'b0;
      frame_err_d = 1'b0;
      cmd_reply_d = cmd_reply_q;
      cmd_adr_d   = cmd_adr_q;
      cmd_data_d  = cmd_data_q;
      n_inc       = (n_q == NW'(FRAME + 1)) ? n_q : n_q + NW'(1);

      if (state_q == IDLE) begin
         n_d   = '0;
         sdo_d = 1'b0;
         if (!sel_s && armed_q) state_d = FLAG;
      end else if (sel_s) begin
         state_d = IDLE;
         n_d     = '0;
         sdo_d   = 1'b0;
         if (n_q == NW'(FRAME)) begin
            cmd_valid_d = 1'b1;
            cmd_adr_d   = shift_q[SW-1 -: ADR_WIDTH];
            cmd_data_d  = shift_q[COMM_WIDTH-1:0];
            cmd_reply_d = ~nrep_q;
         end else if (n_q != '0) begin
            frame_err_d = 1'b1;
         end
      end else if (sck_fall) begin
         n_d     = n_inc;
         shift_d = {shift_q[SW-2:0], sdi_s};
         sdo_d   = 1'b0;
         for (int unsigned i = 0; i < STAT_WIDTH; i++) begin
            if (n_inc == NW'(STAT_WIDTH + 1 - i)) sdo_d = 1'(status >> i);
         end
         if (n_inc == NW'(ADR_WIDTH + 1)) begin
            reply_sh_d = reply_data;
            sdo_d      = ~nrep_q & reply_data[REPLY_WIDTH-1];
         end else if (n_inc > NW'(ADR_WIDTH + 1) && n_inc <= NW'(ADR_WIDTH + REPLY_WIDTH)) begin
            reply_sh_d = (reply_sh_q << 1) | (reply_sh_q >> (REPLY_WIDTH - 1));
            sdo_d      = ~nrep_q & reply_sh_d[REPLY_WIDTH-1];
         end
         case (state_q)
            FLAG: begin
               nrep_d      = sdi_s;
               reply_req_d = ~sdi_s;
               state_d     = ADDR;
            end
            ADDR:    if (n_inc == NW'(ADR_WIDTH + 1)) state_d = DATA;
            DATA:    if (n_inc == NW'(FRAME)) state_d = DONE;
            default: ;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         n_q         <= '0;
         armed_q     <= 1'b0;
         nrep_q      <= 1'b0;
         shift_q     <= '0;
         reply_sh_q  <= '0;
         sdo_q       <= 1'b0;
         reply_req_q <= 1'b0;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         cmd_reply_q <= 1'b0;
         cmd_adr_q   <= '0;
         cmd_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         armed_q     <= armed_d;
         nrep_q      <= nrep_d;
         shift_q     <= shift_d;
         reply_sh_q  <= reply_sh_d;
         sdo_q       <= sdo_d;
         reply_req_q <= reply_req_d;
         cmd_valid_q <= cmd_valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         cmd_reply_q <= cmd_reply_d;
         cmd_adr_q   <= cmd_adr_d;
         cmd_data_q  <= cmd_data_d;
      end
   end

   assign sdo       = sdo_q;
   assign reply_req = reply_req_q;
   assign cmd_valid = cmd_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;
   assign cmd_reply = cmd_reply_q;
   assign cmd_adr   = cmd_adr_q;
   assign cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Bench for spi_cmd_slave: directed frames, a frame-level model of sdo and
// the command/error events, and a per-cycle monitor of the DUT outputs.
module tb_spi_cmd_slave;

   localparam int ADR   = 3;
   localparam int COMM  = 8;
   localparam int REPLY = 8;
   localparam int STAT  = 2;
   localparam int FRAME = 1 + ADR + COMM;
   localparam int HALF  = 5;

   typedef struct {
      logic       err;
      logic [2:0] adr;
      logic [7:0] data;
      logic       rep;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sck = 1'b1;
   logic       sel = 1'b1;
   logic       sdi = 1'b0;
   logic [1:0] status = 2'b00;
   logic [7:0] reply_data = 8'h00;
   logic       sdo, reply_req, cmd_valid, cmd_reply, frame_err, busy;
   logic [2:0] cmd_adr;
   logic [7:0] cmd_data;

   int   checks = 0;
   int   errors = 0;
   int   rr_seen = 0;
   int   exp_rr = 0;
   ev_t  exp_q[$];
   ev_t  ev;
   logic [2:0]  m_adr = 3'd0;
   logic [7:0]  m_data = 8'd0;
   logic        m_reply = 1'b0;
   logic [15:0] seq;

   always #5 clk = ~clk;

   spi_cmd_slave #(
      .REPLY_WIDTH(REPLY), .COMM_WIDTH(COMM), .ADR_WIDTH(ADR),
      .STAT_WIDTH(STAT), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst(rst), .sck(sck), .sel(sel), .sdi(sdi), .sdo(sdo),
      .status(status), .reply_data(reply_data), .reply_req(reply_req),
      .cmd_valid(cmd_valid), .cmd_adr(cmd_adr), .cmd_data(cmd_data),
      .cmd_reply(cmd_reply), .frame_err(frame_err), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // sdo seen by the master after falling edge k
   function automatic logic exp_sdo(input int k, input logic nrep,
                                    input logic [1:0] st, input logic [7:0] rd);
      logic [1:0] ts;
      logic [7:0] tr;
      if (k >= 2 && k <= STAT + 1) begin
         ts = st >> (STAT + 1 - k);
         return ts[0];
      end
      if (!nrep && k >= ADR + 1 && k <= ADR + REPLY) begin
         tr = rd >> (REPLY + ADR - k);
         return tr[0];
      end
      return 1'b0;
   endfunction

   // One SPI transaction; rst_at > 0 pulses reset right after that falling edge
   task automatic spi_frame(input logic nrep, input logic [2:0] adr, input logic [7:0] data,
                            input int nedges, input int rst_at, input int gap,
                            output logic [15:0] sq);
      logic [11:0] bits, tmp;
      logic        hit_rst;
      bits    = {nrep, adr, data};
      sq      = '0;
      hit_rst = 1'b0;
      @(negedge clk);
      sel = 1'b0;
      repeat (4) @(negedge clk);
      for (int k = 1; k <= nedges; k++) begin
         if (k <= FRAME) begin
            tmp = bits >> (FRAME - k);
            sdi = tmp[0];
         end else begin
            sdi = 1'b0;
         end
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
         if (k == rst_at) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            hit_rst = 1'b1;
            repeat (HALF - 2) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         sck = 1'b1;
         sq = {sq[14:0], sdo};
         chk("sdo_bit", sdo, hit_rst ? 1'b0 : exp_sdo(k, nrep, status, reply_data));
         chk("busy_in_frame", busy, hit_rst ? 1'b0 : 1'b1);
      end
      repeat (HALF) @(negedge clk);
      if (!hit_rst) begin
         if (nedges == FRAME) exp_q.push_back('{1'b0, adr, data, ~nrep});
         else if (nedges >= 1) exp_q.push_back('{1'b1, 3'd0, 8'd0, 1'b0});
      end
      if (!nrep && nedges >= 1) exp_rr++;
      sel = 1'b1;
      repeat (gap) @(negedge clk);
      if (gap >= 4) chk("busy_idle", busy, 1'b0);
   endtask

   // Per-cycle monitor: pulses against the expected event queue, held outputs against the model
   always @(negedge clk) begin
      if (rst) begin
         m_adr   = 3'd0;
         m_data  = 8'd0;
         m_reply = 1'b0;
      end else begin
         if (reply_req) rr_seen++;
         if (cmd_valid || frame_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {30'd0, cmd_valid, frame_err}, 32'd0);
            end else begin
               ev = exp_q.pop_front();
               chk("pulse_kind", {30'd0, cmd_valid, frame_err}, ev.err ? 32'd1 : 32'd2);
               if (!ev.err) begin
                  m_adr   = ev.adr;
                  m_data  = ev.data;
                  m_reply = ev.rep;
               end
            end
         end
         chk("cmd_adr", cmd_adr, m_adr);
         chk("cmd_data", cmd_data, m_data);
         chk("cmd_reply", cmd_reply, m_reply);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_outputs", {25'd0, sdo, reply_req, cmd_valid, frame_err, busy, cmd_reply, 1'b0},
          32'd0);
      chk("rst_cmd", {21'd0, cmd_adr, cmd_data}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      chk("idle_sdo", sdo, 1'b0);

      // Reply frame
      status = 2'b10; reply_data = 8'h3C;
      spi_frame(1'b0, 3'b101, 8'hA5, FRAME, 0, 6, seq);
      chk("reply_sdo_seq", seq[10:1], 10'b1000111100);
      chk("reply_adr_lit", cmd_adr, 3'd5);
      chk("reply_data_lit", cmd_data, 8'hA5);
      chk("reply_flag_lit", cmd_reply, 1'b1);
      chk("reply_req_once", rr_seen, 1);

      // No-reply frame
      status = 2'b11; reply_data = 8'hFF;
      spi_frame(1'b1, 3'b010, 8'h01, FRAME, 0, 6, seq);
      chk("norep_sdo_seq", seq[10:1], 10'b1100000000);
      chk("norep_adr_lit", cmd_adr, 3'd2);
      chk("norep_data_lit", cmd_data, 8'h01);
      chk("norep_flag_lit", cmd_reply, 1'b0);
      chk("norep_no_req", rr_seen, 1);

      // Short and long frames
      status = 2'b01; reply_data = 8'h96;
      spi_frame(1'b1, 3'b111, 8'hFF, 7, 0, 6, seq);
      chk("short_keep_adr", cmd_adr, 3'd2);
      chk("short_keep_data", cmd_data, 8'h01);
      spi_frame(1'b0, 3'b110, 8'h77, FRAME + 1, 0, 6, seq);
      chk("long_keep_adr", cmd_adr, 3'd2);

      // Reset in the middle of a frame, sel held low across it
      spi_frame(1'b0, 3'b011, 8'h5A, FRAME, 6, 6, seq);
      chk("after_rst_cmd", {21'd0, cmd_adr, cmd_data}, 32'd0);
      chk("after_rst_flags", {28'd0, sdo, cmd_valid, frame_err, cmd_reply}, 32'd0);

      // Full frame after the reset
      status = 2'b01; reply_data = 8'hA5;
      spi_frame(1'b0, 3'b111, 8'h3C, FRAME, 0, 6, seq);
      chk("post_rst_sdo_seq", seq[10:1], 10'b0110100101);
      chk("post_rst_adr_lit", cmd_adr, 3'd7);
      chk("post_rst_data_lit", cmd_data, 8'h3C);

      // Back-to-back frames with sel high for 3 clk in between
      status = 2'b00; reply_data = 8'h81;
      spi_frame(1'b1, 3'b100, 8'h5A, FRAME, 0, 2, seq);
      spi_frame(1'b0, 3'b001, 8'hC3, FRAME, 0, 6, seq);
      chk("b2b_adr_lit", cmd_adr, 3'd1);
      chk("b2b_data_lit", cmd_data, 8'hC3);
      chk("b2b_flag_lit", cmd_reply, 1'b1);

      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      chk("events_drained", exp_q.size(), 0);
      chk("reply_req_count", rr_seen, exp_rr);
      chk("reply_req_total_lit", rr_seen, 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
